// File: rtl/mpu_pkg.sv
// Shared MPU types. The tile/row typedefs are also used by the outer-product
// accumulator, so a drain engine's tile input wires straight onto reg_c.
//   MpuXlen / MpuVl / MpuMl : default element width, row length, rows per tile
//   row_t                   : one vl-element row
//   tile_t                  : ml rows, row r = tile[r]
//   drain_state_e           : tile readout FSM states
package mpu_pkg;

  localparam int unsigned MpuXlen = 8;
  localparam int unsigned MpuVl   = 4;
  localparam int unsigned MpuMl   = 4;

  typedef logic [MpuVl-1:0][MpuXlen-1:0] row_t;
  typedef row_t [MpuMl-1:0] tile_t;

  typedef enum logic [0:0] {IDLE, DRAIN} drain_state_e;

endpackage

// File: rtl/opacc_drain.sv
// Tile readout engine for the outer-product accumulator.
// On start, snapshots the ml x vl tile and streams it out one row per
// valid/ready handshake, highest row index first, so that feeding the stream
// back into the accumulator's row-serial C load restores the tile.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   start, abort         : request a drain / cancel a drain in progress
//   tile_i               : accumulator tile (sampled only when a start is accepted)
//   busy                 : drain in progress
//   row_valid, row_ready : output row handshake
//   row_data, row_idx    : current row and its tile row index
//   row_last             : current row is the final one
//   done                 : one-cycle pulse after the final transfer
module opacc_drain
  import mpu_pkg::*;
#(
  parameter int unsigned XLEN = MpuXlen,
  parameter int unsigned vl   = MpuVl,
  parameter int unsigned ml   = MpuMl
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [ml-1:0][vl-1:0][XLEN-1:0]   tile_i,
  output logic                              busy,
  output logic                              row_valid,
  input  logic                              row_ready,
  output logic [vl-1:0][XLEN-1:0]           row_data,
  output logic [$clog2(ml)-1:0]             row_idx,
  output logic                              row_last,
  output logic                              done
);

  localparam int unsigned CntW = $clog2(ml);
  localparam logic [CntW-1:0] CntLast = CntW'(ml - 1);

  drain_state_e                    state_q;
  logic [CntW-1:0]                 cnt_q;
  logic [ml-1:0][vl-1:0][XLEN-1:0] snap_q;
  logic                            done_q;

  logic                            in_drain;
  logic [CntW-1:0]                 cur_idx;

  // Outputs are decoded from registered state only; in IDLE they are forced
  // to zero so they match the reset values regardless of counter/snapshot.
  always_comb begin
    in_drain  = (state_q == DRAIN);
    cur_idx   = CntLast - cnt_q;
    busy      = in_drain;
    row_valid = in_drain;
    row_idx   = in_drain ? cur_idx : '0;
    row_data  = in_drain ? snap_q[cur_idx] : '0;
    row_last  = in_drain && (cnt_q == CntLast);
    done      = done_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      snap_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          // abort in IDLE suppresses a simultaneous start
          if (start && !abort) begin
            snap_q  <= tile_i;
            cnt_q   <= '0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // abort wins over a simultaneous final transfer: no done pulse
          if (abort) begin
            state_q <= IDLE;
          end else if (row_ready) begin
            if (cnt_q == CntLast) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opacc_drain.sv
module tb_opacc_drain;
  import mpu_pkg::*;

  localparam int ML = int'(MpuMl);
  localparam int VL = int'(MpuVl);

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  start = 1'b0;
  logic                  abort = 1'b0;
  logic                  row_ready = 1'b0;
  tile_t                 tile_in = '0;
  logic                  busy;
  logic                  row_valid;
  row_t                  row_data;
  logic [$clog2(ML)-1:0] row_idx;
  logic                  row_last;
  logic                  done;

  int   n_checks = 0;
  int   n_fail = 0;
  row_t loop_q[$];

  opacc_drain dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .abort     (abort),
    .tile_i    (tile_in),
    .busy      (busy),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic tile_t pattern_tile();
    tile_t t;
    for (int r = 0; r < ML; r++)
      for (int j = 0; j < VL; j++)
        t[r][j] = 8'(16 * r + j);
    return t;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int r = 0; r < ML; r++)
      for (int j = 0; j < VL; j++)
        t[r][j] = 8'($urandom);
    return t;
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Called in the first DRAIN cycle. Expected rows come from the tile in
  // emission order ml-1 .. 0. Ends in the cycle after the final edge.
  // mode 0: ready always high, 1: ready pattern 1,0,0,..., 2: random ready.
  task automatic drain_rows(input string tag, input tile_t exp, input int mode,
                            input bit disturb, input bit abort_last);
    int   k = 0;
    int   cyc = 0;
    bit   r;
    bit   aborted = 1'b0;
    row_t obs;
    loop_q.delete();
    while (k < ML && cyc < 64 && !aborted) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      row_ready = r;
      if (disturb && k == 1) begin
        tile_in = '1;
        start   = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (abort_last && k == ML - 1 && r) abort = 1'b1;
      check({tag, "_valid"}, 64'(row_valid), 64'(1));
      check({tag, "_busy"}, 64'(busy), 64'(1));
      check({tag, "_idx"}, 64'(row_idx), 64'(ML - 1 - k));
      check({tag, "_data"}, 64'(row_data), 64'(exp[ML-1-k]));
      check({tag, "_last"}, 64'(row_last), 64'(k == ML - 1));
      check({tag, "_nodone"}, 64'(done), 64'(0));
      obs = row_data;
      tick();
      cyc++;
      if (abort) begin
        abort   = 1'b0;
        aborted = 1'b1;
      end
      if (r) begin
        loop_q.push_back(obs);
        k++;
      end
    end
    start     = 1'b0;
    row_ready = 1'b0;
    check({tag, "_xfers"}, 64'(k), 64'(ML));
    check({tag, "_end_done"}, 64'(done), 64'(!aborted));
    check({tag, "_end_busy"}, 64'(busy), 64'(0));
    check({tag, "_end_valid"}, 64'(row_valid), 64'(0));
  endtask

  // Accumulator C shift-load model: k-th loaded row lands at index ml-1-k.
  task automatic check_loopback(input string tag, input tile_t exp);
    row_t acc[ML];
    for (int r = 0; r < ML; r++) acc[r] = '0;
    for (int k = 0; k < loop_q.size() && k < ML; k++) acc[ML-1-k] = loop_q[k];
    for (int r = 0; r < ML; r++) check({tag, "_reg_c"}, 64'(acc[r]), 64'(exp[r]));
  endtask

  initial begin
    tile_t pat;
    pat = pattern_tile();
    tile_in = pat;

    // Reset state
    #12;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_valid", 64'(row_valid), 64'(0));
    check("rst_idx", 64'(row_idx), 64'(0));
    check("rst_data", 64'(row_data), 64'(0));
    check("rst_last", 64'(row_last), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Basic drain with loopback into the accumulator model
    row_ready = 1'b1;
    do_start();
    check("basic_row3_word", 64'(row_data), 64'h33323130);
    drain_rows("basic", pat, 0, 1'b0, 1'b0);
    check_loopback("loop", pat);
    tick();
    check("basic_done_once", 64'(done), 64'(0));

    // Backpressure
    do_start();
    drain_rows("bp", pat, 1, 1'b0, 1'b0);
    tick();

    // Snapshot isolation and ignored start mid-drain
    do_start();
    drain_rows("iso", pat, 0, 1'b1, 1'b0);
    tile_in = pat;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("iso_no_redrain", 64'(busy), 64'(0));
      check("iso_single_done", 64'(done), 64'(0));
    end

    // Abort after two transfers
    row_ready = 1'b1;
    do_start();
    tick();
    tick();
    abort = 1'b1;
    row_ready = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_valid", 64'(row_valid), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    tick();
    check("abort_done_late", 64'(done), 64'(0));

    // Fresh drain after abort
    do_start();
    drain_rows("fresh", pat, 0, 1'b0, 1'b0);
    tick();

    // Abort together with the final transfer: no done
    do_start();
    drain_rows("abort_last", pat, 0, 1'b0, 1'b1);
    tick();
    check("abort_last_done_late", 64'(done), 64'(0));

    // Abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("abort_vs_start", 64'(busy), 64'(0));

    // Back-to-back: start in the done cycle
    do_start();
    drain_rows("b2b_a", pat, 0, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_valid", 64'(row_valid), 64'(1));
    check("b2b_idx", 64'(row_idx), 64'(ML - 1));
    drain_rows("b2b_b", pat, 0, 1'b0, 1'b0);
    tick();

    // Asynchronous reset during a stall
    row_ready = 1'b0;
    do_start();
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_valid", 64'(row_valid), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_data", 64'(row_data), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    check("arst_after_busy", 64'(busy), 64'(0));
    check("arst_after_done", 64'(done), 64'(0));

    // Random tiles with random backpressure
    for (int it = 0; it < 6; it++) begin
      tile_t rt;
      rt = rand_tile();
      tile_in = rt;
      do_start();
      tile_in = rand_tile();
      drain_rows("rand", rt, 2, 1'b0, 1'b0);
      check_loopback("rand_loop", rt);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/opacc_drain.md
# opacc_drain

Tile readout engine for the MPU outer-product accumulator. On `start` it snapshots the full ml×vl accumulator tile, then streams it out one vl-element row per valid/ready handshake. Row order is chosen so that feeding the stream straight back into the accumulator's `c_valid`/`vi_c` shift-load port reproduces the original tile. It sits between the accumulator's `reg_c` array and the vector writeback path. It is the read-out counterpart of the accumulator's row-serial C load.

## Interface
- `XLEN`, 8, element width in bits
- `vl`, 4, elements per row (columns)
- `ml`, 4, rows per tile; must be ≥2
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  request a drain; accepted only when `busy`=0
- `abort`  in  1  cancel an in-progress drain
- `tile_i`  in  ml×vl×XLEN  accumulator tile; row r = `tile_i[r]`
- `busy`  out  1  drain in progress (state DRAIN)
- `row_valid`  out  1  `row_data` holds a valid row
- `row_ready`  in  1  downstream accepts the row
- `row_data`  out  vl×XLEN  current row
- `row_idx`  out  $clog2(ml)  tile row index of `row_data`
- `row_last`  out  1  current row is the final one of the tile
- `done`  out  1  one-cycle pulse after the final handshake

## Operation
- States: IDLE, DRAIN.
- IDLE, `start`=1 at an edge:
  - copy `tile_i` into the internal snapshot buffer;
  - clear the row counter `cnt`;
  - go to DRAIN.
- DRAIN:
  - `row_valid`=1.
  - `row_idx` = ml-1-`cnt`.
  - `row_data` = snapshot[ml-1-`cnt`].
  - `row_last` = (`cnt`==ml-1).
  - Emission order is ml-1 down to 0. The accumulator shift-load puts the first row in at index ml-1, so this order makes a re-load restore the tile.
- Handshake: a transfer occurs when `row_valid`&`row_ready` are both high at an edge.
  - On a transfer, `cnt` increments.
  - On a transfer with `row_last`, go to IDLE and assert `done` for the next cycle.
- Valid/data rules:
  - Once asserted, `row_valid` stays high until the transfer.
  - `row_data`, `row_idx` and `row_last` are stable while `row_valid`=1 and `row_ready`=0.
  - `row_valid` never depends combinationally on `row_ready`.
- Snapshot isolation: `tile_i` is ignored outside the `start` edge. Changes to `tile_i` during DRAIN must not affect the output.
- `start` while `busy`=1 is ignored. It is not queued.
- `abort`:
  - in DRAIN, go to IDLE at the next edge with no `done` pulse;
  - `abort` takes priority over a simultaneous final transfer, so no `done` is issued;
  - in IDLE, `abort` has priority over `start`, so the start is not accepted.
- Widths: `cnt` is $clog2(ml) bits. It never wraps past ml-1 because the transition to IDLE happens at the final transfer.

## Timing
- Reset values (`reset_n`=0, asynchronous): state IDLE, `busy`=0, `row_valid`=0, `row_last`=0, `done`=0, `row_idx`=0, `row_data`=0, snapshot=0, `cnt`=0.
- Reset asserted mid-drain: all outputs return immediately to their reset values. No `done` pulse.
- Start latency: `start` sampled at edge N gives `busy`=`row_valid`=1 in the cycle after N, with `row_idx`=ml-1.
- Throughput: one row per cycle with `row_ready` held high. A full tile takes ml cycles of DRAIN.
- Final transfer at edge M:
  - in the cycle after M, `done`=1, `busy`=0, `row_valid`=0;
  - a `start` sampled at edge M+1 is accepted.
  - Minimum start-to-start spacing is therefore ml+1 cycles.
- All outputs are registered or decoded from registered state only. There is no combinational input-to-output path.

## Structure
- The shared package `mpu_pkg` holds:
  - `row_t`, defined as logic [vl-1:0][XLEN-1:0];
  - `tile_t`, defined as `row_t` [ml-1:0];
  - the `drain_state_e` enum {IDLE, DRAIN}.
- These typedefs are shared with the accumulator so that `tile_i` connects directly to `reg_c`.
- Single module, no sub-modules. The snapshot buffer, counter and two-state FSM fit in one file.

## Test plan
Every scenario runs with XLEN=8, vl=ml=4, and `tile_i[r][j]` = 16·r+j.

- **Reset and basic drain:** deassert `reset_n`, pulse `start`, hold `row_ready`=1.
  - `row_idx` must read 3,2,1,0 on consecutive cycles.
  - `row_data[j]` must be 16·`row_idx`+j (the row-3 word is 0x33323130).
  - `row_last` must be high only with idx 0, and `done` must pulse on the following cycle.
- **Backpressure:** toggle `row_ready` 1,0,0,1,… during a drain.
  - Outputs must hold stable during every stall.
  - Exactly 4 transfers must occur with the correct data.
- **Snapshot isolation and ignored start:** after `start`, set `tile_i` to all 0xFF and pulse `start` again mid-drain.
  - The original values must stream out.
  - There must be a single `done` and no second drain.
- **Abort:**
  - Assert `abort` after 2 transfers: the next cycle must have `busy`=0 and `row_valid`=0, with no `done`.
  - A following `start` must drain a fresh 3,2,1,0 sequence.
- **Back-to-back and reset mid-drain:**
  - A `start` in the `done` cycle must be accepted, with `row_valid` high on the next cycle.
  - Asynchronous `reset_n` low during a stall must clear `row_valid` and `busy` immediately, with no `done`.
- **Loopback:** connect `row_valid`&`row_ready` to the accumulator's `c_valid` and `row_data` to its `vi_c`.
  - After a drain, the accumulator `reg_c` must equal the original tile row for row.
